// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM state encoding and small helpers.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    HOLD = 2'd3
  } arb_state_t;

  // Width of the hold timer; a disabled timeout still needs a 1-bit register.
  function automatic int timer_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

  // Index that lies 'offset' places above 'base', wrapping at n.
  function automatic int rr_wrap(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or above ptr, wrapping around.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;
  logic          found;

  // Scan upward from the pointer and keep only the first valid candidate.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'(rr_wrap(int'(ptr), k, N));
      if (!found && valid[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers; a winner owns the line for a whole message.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 1024,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout_err
);

  localparam int TMR_W = timer_width(HOLD_TIMEOUT);
  localparam bit TMR_EN = (HOLD_TIMEOUT > 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_EN ? TMR_W'(HOLD_TIMEOUT - 1) : '0;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  arb_state_t         state;
  logic [ID_W-1:0]    rr_ptr;
  logic               last_q;
  logic [TMR_W-1:0]   hold_timer;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]    sel_idx;
  logic [ID_W-1:0]    next_ptr;
  logic               handshake;

  uart_tx_arbiter_rr_pick #(.N(NUM_REQ)) u_pick (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign sel_idx      = (state == HOLD) ? grant_id : pick_idx;
  assign next_ptr     = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  assign handshake    = |(req_valid & req_ready);

  // Accept window: a fresh round-robin winner in IDLE, only the current owner while holding.
  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      case (state)
        IDLE: if (pick_any && !tx_busy) req_ready = pick_onehot;
        HOLD: req_ready = grant_onehot;
        default: req_ready = '0;
      endcase
    end
  end

  // Arbiter FSM: latch the byte, hold start until uart_tx goes busy, then wait out the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      last_q      <= 1'b0;
      hold_timer  <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            tx_data     <= req_data[{sel_idx, 3'b000} +: 8];
            last_q      <= req_last[sel_idx];
            grant_id    <= sel_idx;
            grant_valid <= 1'b1;
            tx_start    <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (tx_busy) begin
            tx_start <= 1'b0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            if (last_q) begin
              grant_valid <= 1'b0;
              rr_ptr      <= next_ptr;
              state       <= IDLE;
            end else begin
              hold_timer <= '0;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (handshake) begin
            tx_data     <= req_data[{sel_idx, 3'b000} +: 8];
            last_q      <= req_last[sel_idx];
            grant_id    <= sel_idx;
            grant_valid <= 1'b1;
            tx_start    <= 1'b1;
            hold_timer  <= '0;
            state       <= LOAD;
          end else if (TMR_EN && hold_timer == TMR_LAST) begin
            grant_valid <= 1'b0;
            rr_ptr      <= next_ptr;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else if (TMR_EN) begin
            hold_timer <= hold_timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural uart_tx busy model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int HOLD_TIMEOUT = 16;
  localparam int ID_W         = 2;
  localparam int START_DLY    = 3;
  localparam int BUSY_CYC     = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #20 clk = ~clk;

  // uart_tx stand-in: start seen only after a clock-enable delay, then busy for a frame.
  logic [7:0] m_byte;
  int         m_phase;
  int         m_cnt;
  int         data_viol = 0;
  logic [7:0] sent_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      m_phase <= 0;
      m_cnt   <= 0;
      m_byte  <= 8'h00;
    end else begin
      case (m_phase)
        0: if (tx_start) begin
          m_byte  <= tx_data;
          m_cnt   <= START_DLY;
          m_phase <= 1;
        end
        1: if (m_cnt == 0) begin
          tx_busy <= 1'b1;
          sent_q.push_back(m_byte);
          m_cnt   <= BUSY_CYC;
          m_phase <= 2;
        end else begin
          m_cnt <= m_cnt - 1;
        end
        default: begin
          if (tx_data !== m_byte) data_viol <= data_viol + 1;
          if (m_cnt == 0) begin
            tx_busy <= 1'b0;
            m_phase <= 0;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
      endcase
    end
  end

  // Continuous watch on start length, start-while-busy behaviour and the lock window.
  int   start_run = 0;
  int   max_run = 0;
  int   start_viol = 0;
  int   lock_viol = 0;
  logic prev_start = 1'b0;
  logic prev_sb = 1'b0;
  logic lock_window = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) start_run <= start_run + 1;
      else start_run <= 0;
      if (tx_start && (start_run + 1 > max_run)) max_run <= start_run + 1;
      if (tx_start && tx_busy && (prev_sb || !prev_start)) start_viol <= start_viol + 1;
      if (lock_window && req_ready[2]) lock_viol <= lock_viol + 1;
    end
    prev_start <= tx_start;
    prev_sb    <= tx_start && tx_busy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte from requester i and return at the negedge after its handshake.
  task automatic applyStimulus(input int i, input logic [7:0] d, input logic l, input string tag);
    int n;
    n = 0;
    req_valid[i]      = 1'b1;
    req_data[8*i +: 8] = d;
    req_last[i]       = l;
    #1;
    while (!req_ready[i] && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      checkOutput({tag, "_ready_timeout"}, 32'(req_ready[i]), 32'd1);
      req_valid[i] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (!(grant_valid == 1'b0 && tx_busy == 1'b0 && tx_start == 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkOutput({tag, "_idle_timeout"}, 32'(grant_valid), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int cnt;

    // Reset values, with every requester asking so req_ready gating is visible
    rst_n     = 1'b0;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_tx_start", 32'(tx_start), 32'h0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h0);
    checkOutput("rst_grant_valid", 32'(grant_valid), 32'h0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'h0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'h0);
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);

    // Single two-byte message from requester 0
    sent_q.delete();
    applyStimulus(0, 8'hC0, 1'b0, "t1_b0");
    checkOutput("t1_grant_valid", 32'(grant_valid), 32'd1);
    checkOutput("t1_grant_id", 32'(grant_id), 32'd0);
    applyStimulus(0, 8'h55, 1'b1, "t1_b1");
    checkOutput("t1_grant_valid_mid", 32'(grant_valid), 32'd1);
    waitIdle("t1");
    checkOutput("t1_grant_valid_end", 32'(grant_valid), 32'd0);
    checkOutput("t1_count", 32'(sent_q.size()), 32'd2);
    checkOutput("t1_byte0", 32'(sent_q[0]), 32'hC0);
    checkOutput("t1_byte1", 32'(sent_q[1]), 32'h55);

    // Contention: req1 and req3 together from pointer 0, then pointer movement
    doReset();
    sent_q.delete();
    req_data[15:8]  = 8'h21;
    req_last[1]     = 1'b1;
    req_data[31:24] = 8'h23;
    req_last[3]     = 1'b1;
    req_valid       = 4'b1010;
    #1;
    checkOutput("t2_ready_first", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    checkOutput("t2_grant_id_1", 32'(grant_id), 32'd1);
    req_valid[1]   = 1'b0;
    req_data[7:0]  = 8'h20;
    req_last[0]    = 1'b1;
    req_valid[0]   = 1'b1;
    @(negedge clk);
    waitIdle("t2_w1");
    #1;
    checkOutput("t2_ready_second", 32'(req_ready), 32'b1000);
    @(posedge clk);
    #1;
    checkOutput("t2_grant_id_3", 32'(grant_id), 32'd3);
    req_valid[3] = 1'b0;
    @(negedge clk);
    waitIdle("t2_w2");
    req_data[31:24] = 8'h33;
    req_valid[3]    = 1'b1;
    #1;
    checkOutput("t2_ready_third", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    waitIdle("t2_w3");
    checkOutput("t2_count", 32'(sent_q.size()), 32'd3);
    checkOutput("t2_byte0", 32'(sent_q[0]), 32'h21);
    checkOutput("t2_byte1", 32'(sent_q[1]), 32'h23);
    checkOutput("t2_byte2", 32'(sent_q[2]), 32'h20);

    // Lock: req2 waits through req0's three-byte message
    doReset();
    sent_q.delete();
    req_data[23:16] = 8'hAA;
    req_last[2]     = 1'b1;
    req_valid[2]    = 1'b1;
    applyStimulus(0, 8'h01, 1'b0, "t3_b0");
    lock_window = 1'b1;
    applyStimulus(0, 8'h02, 1'b0, "t3_b1");
    applyStimulus(0, 8'h03, 1'b1, "t3_b2");
    lock_window = 1'b0;
    checkOutput("t3_grant_id_0", 32'(grant_id), 32'd0);
    applyStimulus(2, 8'hAA, 1'b1, "t3_b3");
    checkOutput("t3_grant_id_2", 32'(grant_id), 32'd2);
    waitIdle("t3");
    checkOutput("t3_lock_viol", 32'(lock_viol), 32'd0);
    checkOutput("t3_count", 32'(sent_q.size()), 32'd4);
    checkOutput("t3_byte0", 32'(sent_q[0]), 32'h01);
    checkOutput("t3_byte2", 32'(sent_q[2]), 32'h03);
    checkOutput("t3_byte3", 32'(sent_q[3]), 32'hAA);

    // Timeout: req1 stalls mid-message, req2 takes over after the pulse
    doReset();
    sent_q.delete();
    applyStimulus(1, 8'h11, 1'b0, "t4_b0");
    req_data[23:16] = 8'h22;
    req_last[2]     = 1'b1;
    req_valid[2]    = 1'b1;
    n = 0;
    while (!tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("t4_busy_timeout", 32'(tx_busy), 32'd0);
    cnt = 0;
    while (!timeout_err && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("t4_timeout_delay", 32'(cnt), 32'd17);
    checkOutput("t4_grant_drop", 32'(grant_valid), 32'd0);
    #1;
    checkOutput("t4_ready_after", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1;
    checkOutput("t4_pulse_width", 32'(timeout_err), 32'd0);
    checkOutput("t4_grant_id", 32'(grant_id), 32'd2);
    req_valid = '0;
    @(negedge clk);
    waitIdle("t4");
    checkOutput("t4_count", 32'(sent_q.size()), 32'd2);
    checkOutput("t4_byte1", 32'(sent_q[1]), 32'h22);

    // Reset in the middle of a frame, then a clean message
    doReset();
    applyStimulus(3, 8'h5A, 1'b1, "t5_b0");
    n = 0;
    while (!tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    checkOutput("t5_tx_start", 32'(tx_start), 32'd0);
    checkOutput("t5_tx_data", 32'(tx_data), 32'h0);
    checkOutput("t5_grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("t5_grant_id", 32'(grant_id), 32'd0);
    checkOutput("t5_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);
    sent_q.delete();
    applyStimulus(2, 8'hA5, 1'b1, "t5_b1");
    checkOutput("t5_grant_id_after", 32'(grant_id), 32'd2);
    waitIdle("t5");
    checkOutput("t5_count", 32'(sent_q.size()), 32'd1);
    checkOutput("t5_byte0", 32'(sent_q[0]), 32'hA5);

    // Start-hold behaviour and data stability across all traffic above
    checkOutput("t6_start_viol", 32'(start_viol), 32'd0);
    checkOutput("t6_data_viol", 32'(data_viol), 32'd0);
    checkOutput("t6_start_run_ok", 32'(max_run > 0 && max_run <= 25), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
